// File: rtl/qrng_sample_ctrl_if.sv
// Qubit measurement req/ack link plus the random-word valid/ready stream.
// master = sequencer side, slave = MCU link / word consumer side.
interface qrng_sample_ctrl_if #(
  parameter int WORD_W = 8
);
  logic              meas_req;
  logic              meas_ack;
  logic              meas_bit;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output meas_req, out_data, out_valid,
    input  meas_ack, meas_bit, out_ready
  );

  modport slave (
    input  meas_req, out_data, out_valid,
    output meas_ack, meas_bit, out_ready
  );
endinterface

// File: rtl/qrng_sample_ctrl.sv
// Requests qubit measurements, tallies outcomes, packs bits MSB-first into words; word valid 2 cycles after final ack.
// out_valid/out_data hold while out_ready is low with no new requests; QRNG_VON_NEUMANN_EN adds pair debiasing.
module qrng_sample_ctrl #(
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  qrng_sample_ctrl_if.master bus,
  output logic [CNT_W-1:0]   zero_cnt,
  output logic [CNT_W-1:0]   one_cnt,
  output logic               timeout_err,
  output logic               busy
);

  localparam int          BC_W       = $clog2(WORD_W + 1);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PROC, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [15:0]       timer_q, timer_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              bit_q, bit_d;
  logic [CNT_W-1:0]  zero_cnt_q, zero_cnt_d;
  logic [CNT_W-1:0]  one_cnt_q, one_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              busy_q, busy_d;
`ifdef QRNG_VON_NEUMANN_EN
  logic              pair_q, pair_d;
  logic              half_q, half_d;
`endif

  logic              shift_en;
  logic              shift_bit;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    bit_cnt_d     = bit_cnt_q;
    word_d        = word_q;
    out_data_d    = out_data_q;
    bit_d         = bit_q;
    zero_cnt_d    = zero_cnt_q;
    one_cnt_d     = one_cnt_q;
    timeout_err_d = timeout_err_q;
`ifdef QRNG_VON_NEUMANN_EN
    pair_d        = pair_q;
    half_d        = half_q;
`endif
    shift_en      = 1'b0;
    shift_bit     = bit_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end

      S_WAIT: begin
        if (bus.meas_ack) begin
          bit_d   = bus.meas_bit;
          state_d = S_PROC;
        end else if (timer_q == TIMER_LAST) begin
          // Partial word survives a timeout; only a half-pair is dropped.
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
`ifdef QRNG_VON_NEUMANN_EN
          pair_d        = 1'b0;
`endif
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      S_PROC: begin
        if (bit_q) begin
          if (one_cnt_q != '1) one_cnt_d = one_cnt_q + CNT_W'(1);
        end else begin
          if (zero_cnt_q != '1) zero_cnt_d = zero_cnt_q + CNT_W'(1);
        end

`ifdef QRNG_VON_NEUMANN_EN
        // The first bit of an unequal pair is the unbiased output.
        if (!pair_q) begin
          pair_d = 1'b1;
          half_d = bit_q;
        end else begin
          pair_d    = 1'b0;
          shift_en  = (half_q != bit_q);
          shift_bit = half_q;
        end
`else
        shift_en  = 1'b1;
        shift_bit = bit_q;
`endif

        if (shift_en) begin
          word_d    = {word_q[WORD_W-2:0], shift_bit};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end

        if (shift_en && (bit_cnt_q == BC_W'(WORD_W - 1))) begin
          out_data_d = word_d;
          bit_cnt_d  = '0;
          state_d    = S_OUT;
        end else if (enable) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_OUT: begin
        if (bus.out_ready) begin
          if (enable) begin
            state_d = S_WAIT;
            timer_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      bit_cnt_q     <= '0;
      word_q        <= '0;
      out_data_q    <= '0;
      bit_q         <= 1'b0;
      zero_cnt_q    <= '0;
      one_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef QRNG_VON_NEUMANN_EN
      pair_q        <= 1'b0;
      half_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      bit_cnt_q     <= bit_cnt_d;
      word_q        <= word_d;
      out_data_q    <= out_data_d;
      bit_q         <= bit_d;
      zero_cnt_q    <= zero_cnt_d;
      one_cnt_q     <= one_cnt_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
`ifdef QRNG_VON_NEUMANN_EN
      pair_q        <= pair_d;
      half_q        <= half_d;
`endif
    end
  end

  assign bus.meas_req  = (state_q == S_WAIT);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = out_data_q;
  assign zero_cnt      = zero_cnt_q;
  assign one_cnt       = one_cnt_q;
  assign timeout_err   = timeout_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_qrng_sample_ctrl.sv
// Scoreboarded bench for qrng_sample_ctrl (WORD_W=8, CNT_W=4, TIMEOUT=16); follows QRNG_VON_NEUMANN_EN.
module tb_qrng_sample_ctrl;

  localparam int WORD_W  = 8;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] zero_cnt, one_cnt;
  logic             timeout_err, busy;

  qrng_sample_ctrl_if #(.WORD_W(WORD_W)) bus ();

  qrng_sample_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bus         (bus),
    .zero_cnt    (zero_cnt),
    .one_cnt     (one_cnt),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int xfer_cnt = 0;
  logic [WORD_W-1:0] last_word = '0;

  // Reference model state
  logic [WORD_W-1:0] word_m;
  int                cnt_m, zc_m, oc_m;
  logic [WORD_W-1:0] exp_q[$];
`ifdef QRNG_VON_NEUMANN_EN
  logic              pair_m, half_m;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    word_m = '0; cnt_m = 0; zc_m = 0; oc_m = 0;
    exp_q.delete();
`ifdef QRNG_VON_NEUMANN_EN
    pair_m = 1'b0; half_m = 1'b0;
`endif
  endtask

  task automatic model_shift(input logic b);
    word_m = {word_m[WORD_W-2:0], b};
    cnt_m++;
    if (cnt_m == WORD_W) begin
      exp_q.push_back(word_m);
      cnt_m = 0;
    end
  endtask

  task automatic model_ack(input logic b);
    if (b) begin
      if (oc_m < CNT_MAX) oc_m++;
    end else begin
      if (zc_m < CNT_MAX) zc_m++;
    end
`ifdef QRNG_VON_NEUMANN_EN
    if (!pair_m) begin
      pair_m = 1'b1;
      half_m = b;
    end else begin
      pair_m = 1'b0;
      if (half_m != b) model_shift(half_m);
    end
`else
    model_shift(b);
`endif
  endtask

  task automatic model_timeout();
`ifdef QRNG_VON_NEUMANN_EN
    pair_m = 1'b0;
`endif
  endtask

  // Consumer side: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      xfer_cnt++;
      last_word = bus.out_data;
      if (exp_q.size() == 0) chk("pending_words", exp_q.size(), 1);
      else                   chk("word", bus.out_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; bus.meas_ack = 1'b0; bus.meas_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_meas_req"},  bus.meas_req, 0);
    chk({pfx, "_out_valid"}, bus.out_valid, 0);
    chk({pfx, "_out_data"},  bus.out_data, 0);
    chk({pfx, "_zero_cnt"},  zero_cnt, 0);
    chk({pfx, "_one_cnt"},   one_cnt, 0);
    chk({pfx, "_timeout"},   timeout_err, 0);
    chk({pfx, "_busy"},      busy, 0);
  endtask

  task automatic ack(input logic b);
    for (int i = 0; i < 100; i++) begin
      if (bus.meas_req) break;
      step();
    end
    if (!bus.meas_req) begin
      chk("req_wait", bus.meas_req, 1);
      return;
    end
    bus.meas_ack = 1'b1;
    bus.meas_bit = b;
    model_ack(b);
    step();
    bus.meas_ack = 1'b0;
  endtask

  // One accepted bit: a single ack, or an unequal pair under debiasing.
  task automatic send_bit(input logic b);
`ifdef QRNG_VON_NEUMANN_EN
    ack(b);
    ack(~b);
`else
    ack(b);
`endif
  endtask

  task automatic wait_timeout(output int hi);
    bit seen = 1'b0;
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.meas_req) begin
        seen = 1'b1;
        hi++;
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      step();
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0]  pat;
    logic [19:0] vn_seq;
    int          hi, z0, o0, x0;
    bit          stable_ok, req_ok;

    bus.meas_ack  = 1'b0;
    bus.meas_bit  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values and one full word with free-flowing consumer
    do_reset();
    chk_reset_vals("rst");
    pat = 8'b1011_0010;
    enable = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(pat[i]);
    enable = 1'b0;
    step();
    chk("t1_valid_hi", bus.out_valid, 1);
    step();
    chk("t1_valid_lo", bus.out_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_zero", zero_cnt, zc_m);
    chk("t1_one", one_cnt, oc_m);
`ifndef QRNG_VON_NEUMANN_EN
    chk("t1_word_b2", last_word, 8'hB2);
    chk("t1_one_4", one_cnt, 4);
`endif
    drain();

    // Backpressure: word held, no requests, stray acks ignored
    do_reset();
    bus.out_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    step();
    chk("bp_valid", bus.out_valid, 1);
    z0 = zc_m; o0 = oc_m; x0 = xfer_cnt;
    stable_ok = 1'b1; req_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.meas_ack = (i == 5 || i == 9);
      bus.meas_bit = (i == 5);
      step();
      if (bus.out_data !== exp_q[0] || !bus.out_valid) stable_ok = 1'b0;
      if (bus.meas_req) req_ok = 1'b0;
    end
    bus.meas_ack = 1'b0;
    chk("bp_data_stable", stable_ok, 1);
    chk("bp_no_req", req_ok, 1);
    chk("bp_zero_hold", zero_cnt, z0);
    chk("bp_one_hold", one_cnt, o0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_req_again", bus.meas_req, 1);
    chk("bp_valid_lo", bus.out_valid, 0);
    chk("bp_single_xfer", xfer_cnt - x0, 1);

    // Timeout with a partial word of 3 bits, then completion
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    wait_timeout(hi);
    model_timeout();
    chk("to_req_cycles", hi, TIMEOUT);
    chk("to_err", timeout_err, 1);
    chk("to_idle", busy, 0);
    step();
    chk("to_rereq", bus.meas_req, 1);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    enable = 1'b0;
    drain();
    chk("to_err_sticky", timeout_err, 1);

    // Stray acks in IDLE, then tally saturation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.meas_ack = 1'b1;
      bus.meas_bit = i[0];
      step();
    end
    bus.meas_ack = 1'b0;
    step();
    chk("stray_zero", zero_cnt, 0);
    chk("stray_one", one_cnt, 0);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) ack(1'b1);
    enable = 1'b0;
    drain();
    chk("sat_one", one_cnt, CNT_MAX);
    chk("sat_zero", zero_cnt, zc_m);

    // Reset after 5 of 8 bits discards the partial word
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    chk_reset_vals("mid_rst");
    enable = 1'b1;
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) send_bit(pat[i]);
    enable = 1'b0;
    drain();
    chk("mid_rst_word", last_word, 8'h3C);

`ifdef QRNG_VON_NEUMANN_EN
    // Debiasing of the reference pair sequence
    do_reset();
    enable = 1'b1;
    vn_seq = 20'b01_10_00_11_10_01_10_10_01_10;
    for (int i = 19; i >= 0; i--) ack(vn_seq[i]);
    enable = 1'b0;
    drain();
    chk("vn_word", last_word, 8'h6D);
    chk("vn_one", one_cnt, 10);
    chk("vn_zero", zero_cnt, 10);

    // Half-pair dropped by a timeout
    do_reset();
    enable = 1'b1;
    ack(1'b1);
    wait_timeout(hi);
    model_timeout();
    chk("vn_to_cycles", hi, TIMEOUT);
    ack(1'b0);
    ack(1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    enable = 1'b0;
    drain();
    chk("vn_to_word", last_word, 8'h7F);
`endif

    chk("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
